// File: rtl/hack_pkg.sv
// Shared constants and types for the Hack screen reader: screen geometry,
// bus widths and the frame-read state encoding.
package hack_pkg;

  localparam int WORD_W  = 16;
  localparam int ADDR_W  = 15;
  localparam int PIX_X_W = 9;
  localparam int PIX_Y_W = 8;

  localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;
  localparam int SCREEN_ROW_WORDS = 32;
  localparam int SCREEN_ROWS      = 256;
  localparam int SCREEN_WORDS     = SCREEN_ROW_WORDS * SCREEN_ROWS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } reader_state_e;

  // Word address of the idx-th word of the screen region starting at base.
  function automatic logic [ADDR_W-1:0] screen_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/hack_screen_reader_if.sv
// Memory read port plus pixel stream between the screen reader and its
// neighbours (arbiter/memory on one side, display back end on the other).
interface hack_screen_reader_if;
  import hack_pkg::*;

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_gnt;
  logic [WORD_W-1:0]  mem_rdata;

  logic               pix_valid;
  logic               pix_ready;
  logic               pix_data;
  logic [PIX_X_W-1:0] pix_x;
  logic [PIX_Y_W-1:0] pix_y;

  modport master (
    output mem_req, mem_addr, pix_valid, pix_data, pix_x, pix_y,
    input  mem_gnt, mem_rdata, pix_ready
  );

  modport slave (
    input  mem_req, mem_addr, pix_valid, pix_data, pix_x, pix_y,
    output mem_gnt, mem_rdata, pix_ready
  );

endinterface

// File: rtl/pixel_shifter.sv
// Parallel-in serial-out pixel shifter: emits one screen word LSB first
// (bit 0 = leftmost pixel) with a valid/ready handshake.
module pixel_shifter
  import hack_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic              data,
  output logic              can_load
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic [WORD_W-1:0] shift_q;
  logic [CNT_W-1:0]  count_q;
  logic              valid_q;
  logic              accept;
  logic              last;

  assign accept = valid_q & ready;
  assign last   = accept & (count_q == LAST_BIT);
  // A new word may enter when empty, or in the same cycle the final bit leaves.
  assign can_load = !valid_q | last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      shift_q <= load_data;
      count_q <= '0;
      valid_q <= 1'b1;
    end else if (accept) begin
      shift_q <= shift_q >> 1;
      count_q <= count_q + 1'b1;
      if (last) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid = valid_q;
  assign data  = shift_q[0];

endmodule

// File: rtl/hack_screen_reader.sv
// Frame reader for the Hack screen region: fetches words through the shared
// memory port into a one-word prefetch buffer and streams them as pixels.
module hack_screen_reader
  import hack_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = SCREEN_BASE,
  parameter int                ROW_WORDS = SCREEN_ROW_WORDS,
  parameter int                ROWS      = SCREEN_ROWS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  hack_screen_reader_if.master bus,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int FRAME_WORDS = ROW_WORDS * ROWS;
  localparam int IDX_W       = $clog2(FRAME_WORDS + 1);
  localparam logic [IDX_W-1:0]   END_IDX = IDX_W'(FRAME_WORDS);
  localparam logic [PIX_X_W-1:0] LAST_X  = PIX_X_W'(ROW_WORDS * WORD_W - 1);
  localparam logic [PIX_Y_W-1:0] LAST_Y  = PIX_Y_W'(ROWS - 1);

  reader_state_e      state;
  reader_state_e      state_next;
  logic [IDX_W-1:0]   word_idx;
  logic [WORD_W-1:0]  prefetch;
  logic               prefetch_full;
  logic [PIX_X_W-1:0] x_q;
  logic [PIX_Y_W-1:0] y_q;

  logic req;
  logic fetch;
  logic accept;
  logic last_accept;
  logic sh_valid;
  logic sh_data;
  logic sh_can_load;
  logic sh_load;

  assign fetch       = req & bus.mem_gnt;
  assign accept      = sh_valid & bus.pix_ready;
  assign last_accept = accept & (x_q == LAST_X) & (y_q == LAST_Y);
  // Fetch needs an empty buffer and a drain needs a full one, so they never collide.
  assign sh_load     = (state == RUN) & prefetch_full & sh_can_load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req        = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        req  = !prefetch_full & (word_idx < END_IDX);
        if (last_accept) begin
          state_next = DONE;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outside RUN the word counter and buffer are cleared so every frame starts at word 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_idx      <= '0;
      prefetch      <= '0;
      prefetch_full <= 1'b0;
    end else if (state != RUN) begin
      word_idx      <= '0;
      prefetch_full <= 1'b0;
    end else if (fetch) begin
      prefetch      <= bus.mem_rdata;
      prefetch_full <= 1'b1;
      word_idx      <= word_idx + 1'b1;
    end else if (sh_load) begin
      prefetch_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (accept) begin
      if (x_q == LAST_X) begin
        x_q <= '0;
        y_q <= (y_q == LAST_Y) ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  pixel_shifter u_shifter (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (sh_load),
    .load_data (prefetch),
    .ready     (bus.pix_ready),
    .valid     (sh_valid),
    .data      (sh_data),
    .can_load  (sh_can_load)
  );

  assign bus.mem_req   = req;
  assign bus.mem_addr  = req ? screen_addr(BASE_ADDR, ADDR_W'(word_idx)) : '0;
  assign bus.pix_valid = sh_valid;
  assign bus.pix_data  = sh_valid & sh_data;
  assign bus.pix_x     = x_q;
  assign bus.pix_y     = y_q;

endmodule
